// File: rtl/segre_hf_recovery_ctrl.sv
// Precise-exception recovery sequencer: flushes the pipeline, replays history-file
// entries as register-file restore writes, then redirects fetch to the trap vector.
module segre_hf_recovery_ctrl #(
   parameter int unsigned          REG_SIZE     = 5,
   parameter int unsigned          WORD_SIZE    = 32,
   parameter int unsigned          ADDR_SIZE    = 32,
   parameter int unsigned          HF_SIZE      = 8,
   parameter int unsigned          CNT_W        = 4,
   parameter int unsigned          FLUSH_CYCLES = 2,
   parameter logic [ADDR_SIZE-1:0] TRAP_VECTOR  = 32'h0000_2000
) (
   input  logic                 clk_i,
   input  logic                 rsn_i,
   input  logic                 hf_recovering_i,
   input  logic                 hf_empty_i,
   input  logic [REG_SIZE-1:0]  hf_dest_reg_i,
   input  logic [WORD_SIZE-1:0] hf_value_i,
   input  logic [ADDR_SIZE-1:0] exc_pc_i,
   output logic                 flush_o,
   output logic                 stall_o,
   output logic                 rf_we_o,
   output logic [REG_SIZE-1:0]  rf_waddr_o,
   output logic [WORD_SIZE-1:0] rf_wdata_o,
   output logic                 pc_redirect_o,
   output logic [ADDR_SIZE-1:0] pc_target_o,
   output logic [ADDR_SIZE-1:0] epc_o,
   output logic [CNT_W-1:0]     rollback_cnt_o
);

   // The counter must be able to hold a full history file, and the drain counter is 4 bits.
   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || HF_SIZE > (2**CNT_W - 1)) begin : g_param_check
      $error("segre_hf_recovery_ctrl: illegal FLUSH_CYCLES/HF_SIZE/CNT_W combination");
   end

   localparam logic [3:0] DRAIN_INIT = 4'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLUSH    = 2'd1,
      ROLLBACK = 2'd2,
      REDIRECT = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           drain_q, drain_d;
   logic                 flush_q, flush_d;
   logic                 stall_q, stall_d;
   logic                 we_q, we_d;
   logic [REG_SIZE-1:0]  waddr_q, waddr_d;
   logic [WORD_SIZE-1:0] wdata_q, wdata_d;
   logic                 redir_q, redir_d;
   logic [ADDR_SIZE-1:0] tgt_q, tgt_d;
   logic [ADDR_SIZE-1:0] epc_q, epc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         state_q <= IDLE;
         drain_q <= '0;
         flush_q <= 1'b0;
         stall_q <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         redir_q <= 1'b0;
         tgt_q   <= '0;
         epc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         flush_q <= flush_d;
         stall_q <= stall_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         redir_q <= redir_d;
         tgt_q   <= tgt_d;
         epc_q   <= epc_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      tgt_d   = tgt_q;
      epc_d   = epc_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (hf_recovering_i) begin
               state_d = FLUSH;
               epc_d   = exc_pc_i;
               cnt_d   = '0;
               drain_d = DRAIN_INIT;
            end
         end
         FLUSH: begin
            if (drain_q == 4'd0) state_d = ROLLBACK;
            else                 drain_d = drain_q - 4'd1;
         end
         ROLLBACK: begin
            if (!hf_empty_i) begin
               // x0 entries still count as restored but never reach the register file
               we_d    = (hf_dest_reg_i != '0);
               waddr_d = hf_dest_reg_i;
               wdata_d = hf_value_i;
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end else if (!hf_recovering_i) begin
               state_d = REDIRECT;
               tgt_d   = TRAP_VECTOR;
            end
         end
         REDIRECT: state_d = IDLE;
         default:  state_d = IDLE;
      endcase

      // Outputs are registered from the next state so they track the current state.
      flush_d = (state_d == FLUSH);
      stall_d = (state_d != IDLE);
      redir_d = (state_d == REDIRECT);
   end

   assign flush_o        = flush_q;
   assign stall_o        = stall_q;
   assign rf_we_o        = we_q;
   assign rf_waddr_o     = waddr_q;
   assign rf_wdata_o     = wdata_q;
   assign pc_redirect_o  = redir_q;
   assign pc_target_o    = tgt_q;
   assign epc_o          = epc_q;
   assign rollback_cnt_o = cnt_q;

endmodule

// File: tb/tb_segre_hf_recovery_ctrl.sv
// Table-driven bench for segre_hf_recovery_ctrl with hand-written reset and saturation sequences.
module tb_segre_hf_recovery_ctrl;

   logic        clk;
   logic        rsn;
   logic        rec;
   logic        empty;
   logic [4:0]  dest;
   logic [31:0] val;
   logic [31:0] exc;
   logic        flush, stall, we, redir;
   logic [4:0]  waddr;
   logic [31:0] wdata, tgt, epc;
   logic [3:0]  cnt;

   int checks = 0;
   int errors = 0;

   segre_hf_recovery_ctrl dut (
      .clk_i          (clk),
      .rsn_i          (rsn),
      .hf_recovering_i(rec),
      .hf_empty_i     (empty),
      .hf_dest_reg_i  (dest),
      .hf_value_i     (val),
      .exc_pc_i       (exc),
      .flush_o        (flush),
      .stall_o        (stall),
      .rf_we_o        (we),
      .rf_waddr_o     (waddr),
      .rf_wdata_o     (wdata),
      .pc_redirect_o  (redir),
      .pc_target_o    (tgt),
      .epc_o          (epc),
      .rollback_cnt_o (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rec;
      logic        empty;
      logic [4:0]  dest;
      logic [31:0] val;
      logic [31:0] exc;
      logic        e_flush;
      logic        e_stall;
      logic        e_we;
      logic [4:0]  e_waddr;
      logic [31:0] e_wdata;
      logic        e_redir;
      logic [3:0]  e_cnt;
      logic [31:0] e_epc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(logic r, logic e, logic [4:0] d, logic [31:0] x, logic [31:0] pc,
                              logic ef, logic es, logic ew, logic [4:0] ea, logic [31:0] ed,
                              logic er, logic [3:0] ec, logic [31:0] ep);
      vec_t t;
      t.rec = r; t.empty = e; t.dest = d; t.val = x; t.exc = pc;
      t.e_flush = ef; t.e_stall = es; t.e_we = ew; t.e_waddr = ea; t.e_wdata = ed;
      t.e_redir = er; t.e_cnt = ec; t.e_epc = ep;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_row(input int i);
      rec = tbl[i].rec; empty = tbl[i].empty; dest = tbl[i].dest;
      val = tbl[i].val; exc = tbl[i].exc;
      tick();
      check($sformatf("row%0d flush", i), 32'(flush), 32'(tbl[i].e_flush));
      check($sformatf("row%0d stall", i), 32'(stall), 32'(tbl[i].e_stall));
      check($sformatf("row%0d rf_we", i), 32'(we), 32'(tbl[i].e_we));
      check($sformatf("row%0d redirect", i), 32'(redir), 32'(tbl[i].e_redir));
      check($sformatf("row%0d cnt", i), 32'(cnt), 32'(tbl[i].e_cnt));
      check($sformatf("row%0d epc", i), epc, tbl[i].e_epc);
      if (tbl[i].e_we) begin
         check($sformatf("row%0d waddr", i), 32'(waddr), 32'(tbl[i].e_waddr));
         check($sformatf("row%0d wdata", i), wdata, tbl[i].e_wdata);
      end
      if (tbl[i].e_redir) check($sformatf("row%0d target", i), tgt, 32'h0000_2000);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " flush"}, 32'(flush), 0);
      check({tag, " stall"}, 32'(stall), 0);
      check({tag, " rf_we"}, 32'(we), 0);
      check({tag, " waddr"}, 32'(waddr), 0);
      check({tag, " wdata"}, wdata, 0);
      check({tag, " redirect"}, 32'(redir), 0);
      check({tag, " target"}, tgt, 0);
      check({tag, " epc"}, epc, 0);
      check({tag, " cnt"}, 32'(cnt), 0);
   endtask

   initial begin
      int sat_rows;
      logic saw_bad;
      // three-entry recovery (rows 0..7)
      tbl.push_back(v(1,1,0,0,32'h100, 1,1,0,0,0,          0,0,32'h100));
      tbl.push_back(v(1,1,0,0,32'h0,   1,1,0,0,0,          0,0,32'h100));
      tbl.push_back(v(1,1,0,0,32'h0,   0,1,0,0,0,          0,0,32'h100));
      tbl.push_back(v(1,0,5,32'hAAAA,0,0,1,1,5,32'hAAAA,   0,1,32'h100));
      tbl.push_back(v(1,0,6,32'hBBBB,0,0,1,1,6,32'hBBBB,   0,2,32'h100));
      tbl.push_back(v(1,0,7,32'hCCCC,0,0,1,1,7,32'hCCCC,   0,3,32'h100));
      tbl.push_back(v(0,1,0,0,32'h0,   0,1,0,0,0,          1,3,32'h100));
      tbl.push_back(v(0,1,0,0,32'h0,   0,0,0,0,0,          0,3,32'h100));
      // x0 entry between x3 and x4
      tbl.push_back(v(1,1,0,0,32'h200, 1,1,0,0,0,          0,0,32'h200));
      tbl.push_back(v(1,1,0,0,32'h0,   1,1,0,0,0,          0,0,32'h200));
      tbl.push_back(v(1,1,0,0,32'h0,   0,1,0,0,0,          0,0,32'h200));
      tbl.push_back(v(1,0,3,32'h33,0,  0,1,1,3,32'h33,     0,1,32'h200));
      tbl.push_back(v(1,0,0,32'h99,0,  0,1,0,0,0,          0,2,32'h200));
      tbl.push_back(v(1,0,4,32'h44,0,  0,1,1,4,32'h44,     0,3,32'h200));
      tbl.push_back(v(0,1,0,0,32'h0,   0,1,0,0,0,          1,3,32'h200));
      tbl.push_back(v(0,1,0,0,32'h0,   0,0,0,0,0,          0,3,32'h200));
      // empty history file: redirect FLUSH_CYCLES+2 cycles after entry
      tbl.push_back(v(1,1,0,0,32'h300, 1,1,0,0,0,          0,0,32'h300));
      tbl.push_back(v(1,1,0,0,32'h0,   1,1,0,0,0,          0,0,32'h300));
      tbl.push_back(v(0,1,0,0,32'h0,   0,1,0,0,0,          0,0,32'h300));
      tbl.push_back(v(0,1,0,0,32'h0,   0,1,0,0,0,          1,0,32'h300));
      tbl.push_back(v(0,1,0,0,32'h0,   0,0,0,0,0,          0,0,32'h300));
      // empty while still recovering, then a late entry
      tbl.push_back(v(1,1,0,0,32'h400, 1,1,0,0,0,          0,0,32'h400));
      tbl.push_back(v(1,1,0,0,32'h0,   1,1,0,0,0,          0,0,32'h400));
      tbl.push_back(v(1,1,0,0,32'h0,   0,1,0,0,0,          0,0,32'h400));
      tbl.push_back(v(1,1,0,0,32'h0,   0,1,0,0,0,          0,0,32'h400));
      tbl.push_back(v(1,1,0,0,32'h0,   0,1,0,0,0,          0,0,32'h400));
      tbl.push_back(v(1,0,9,32'h9999,0,0,1,1,9,32'h9999,   0,1,32'h400));
      tbl.push_back(v(0,1,0,0,32'h0,   0,1,0,0,0,          1,1,32'h400));
      tbl.push_back(v(0,1,0,0,32'h0,   0,0,0,0,0,          0,1,32'h400));

      rsn = 1'b0; rec = 1'b0; empty = 1'b1; dest = '0; val = '0; exc = '0;
      #12;
      check_all_zero("reset");
      tick();
      rsn = 1'b1;

      // asynchronous reset mid-cycle while in FLUSH
      rec = 1'b1; exc = 32'h55;
      tick();
      check("enter flush", 32'(flush), 1);
      check("enter epc", epc, 32'h55);
      rec = 1'b0;
      #3 rsn = 1'b0;
      #1 check_all_zero("async reset");
      tick();
      rsn = 1'b1;
      tick();
      check("post reset idle stall", 32'(stall), 0);

      for (int i = 0; i < tbl.size(); i++) apply_row(i);

      // reset during ROLLBACK after the first of four writes
      rec = 1'b1; empty = 1'b1; exc = 32'h600;
      tick(); tick(); tick();
      empty = 1'b0; dest = 5'd10; val = 32'hA;
      tick();
      check("abort first write", 32'(we), 1);
      check("abort first waddr", 32'(waddr), 10);
      dest = 5'd11; val = 32'hB;
      #3 rsn = 1'b0;
      #1 check_all_zero("abort reset");
      rec = 1'b0; empty = 1'b1;
      tick(); tick();
      rsn = 1'b1;
      saw_bad = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (we || redir || stall) saw_bad = 1'b1;
      end
      check("abort no further activity", 32'(saw_bad), 0);
      for (int i = 0; i < 8; i++) apply_row(i);

      // rollback counter saturation
      rec = 1'b1; empty = 1'b1; exc = 32'h700;
      tick();
      empty = 1'b0; dest = 5'd1;
      tick(); tick();
      sat_rows = 20;
      for (int k = 0; k < sat_rows; k++) begin
         val = 32'(k);
         tick();
      end
      check("sat cnt", 32'(cnt), 15);
      check("sat we", 32'(we), 1);
      check("sat wdata", wdata, 32'(sat_rows - 1));
      rec = 1'b0; empty = 1'b1;
      tick();
      check("sat redirect", 32'(redir), 1);
      check("sat cnt hold", 32'(cnt), 15);
      tick();
      check("sat idle stall", 32'(stall), 0);
      check("sat epc hold", epc, 32'h700);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/segre_hf_recovery_ctrl.md
Name: segre_hf_recovery_ctrl

Overview:
Sequences precise-exception recovery around the history file. When the history file enters recovery, this block:
- flushes and stalls the pipeline;
- replays each popped history entry as a register-file write, restoring the old architectural values;
- redirects fetch to the trap vector with the excepting PC latched.

It sits between the history file, the register file write port (muxed ahead of writeback) and the fetch stage.

Parameters:
REG_SIZE, 5, register index width
WORD_SIZE, 32, register data width
ADDR_SIZE, 32, PC width
HF_SIZE, 8, history file depth
CNT_W, 4, rollback counter width (holds 0..HF_SIZE)
FLUSH_CYCLES, 2, pipeline drain cycles before rollback starts (1..15)
TRAP_VECTOR, 32'h0000_2000, fetch redirect target

Ports:
clk_i  in  1  clock
rsn_i  in  1  asynchronous active-low reset
hf_recovering_i  in  1  history file in recovery mode
hf_empty_i  in  1  history file empty
hf_dest_reg_i  in  REG_SIZE  destination register of entry popped this cycle
hf_value_i  in  WORD_SIZE  old value of entry popped this cycle
exc_pc_i  in  ADDR_SIZE  PC of excepting instruction, valid when hf_recovering_i first rises
flush_o  out  1  kill all in-flight pipeline instructions
stall_o  out  1  freeze fetch/decode, block history file requests
rf_we_o  out  1  register file restore write enable
rf_waddr_o  out  REG_SIZE  restore write address
rf_wdata_o  out  WORD_SIZE  restore write data
pc_redirect_o  out  1  one-cycle fetch redirect strobe
pc_target_o  out  ADDR_SIZE  redirect target
epc_o  out  ADDR_SIZE  latched excepting PC
rollback_cnt_o  out  CNT_W  entries restored in last/current recovery

Behaviour:
- Single clock domain. Reset is asynchronous and active-low; it applies to all state and outputs.
- Reset values:
  - state=IDLE.
  - All 1-bit outputs 0.
  - rf_waddr_o=0, rf_wdata_o=0, pc_target_o=0, epc_o=0, rollback_cnt_o=0.
- FSM states: IDLE, FLUSH, ROLLBACK, REDIRECT. All outputs are registered, so each output reflects the current state.
- IDLE:
  - flush_o=0, stall_o=0.
  - On hf_recovering_i=1 -> FLUSH. At the same edge: latch exc_pc_i into epc_o, clear rollback_cnt_o, load drain counter with FLUSH_CYCLES-1.
- FLUSH:
  - flush_o=1, stall_o=1, rf_we_o=0.
  - Drain counter decrements each cycle. When it reads 0 -> ROLLBACK.
  - Total FLUSH time is exactly FLUSH_CYCLES cycles.
- ROLLBACK:
  - stall_o=1, flush_o=0.
  - Each cycle with hf_empty_i=0 is one popped entry. For each popped entry:
    - rf_we_o=1 the following cycle, with rf_waddr_o/rf_wdata_o = registered hf_dest_reg_i/hf_value_i;
    - rollback_cnt_o increments, saturating at 2^CNT_W-1.
  - dest_reg 0: counted but rf_we_o suppressed; x0 is never written.
  - Exit when hf_empty_i=1 and hf_recovering_i=0 -> REDIRECT.
  - hf_empty_i=1 with hf_recovering_i still 1: remain in ROLLBACK, no writes.
- REDIRECT:
  - Lasts exactly one cycle: pc_redirect_o=1, pc_target_o=TRAP_VECTOR, stall_o=1, rf_we_o=0.
  - Next state IDLE; stall_o drops the cycle after.
- Recovery with an empty history file (hf_empty_i=1 throughout): FLUSH -> ROLLBACK (1 cycle, 0 writes) -> REDIRECT; rollback_cnt_o=0.
- hf_recovering_i is ignored outside IDLE except as the ROLLBACK exit condition. If it is still 1 on return to IDLE, a new recovery starts on the next edge.
- epc_o and rollback_cnt_o hold until the next recovery begins.
- Minimum recovery latency, entry to redirect strobe: FLUSH_CYCLES + N + 2 cycles for N entries.
- Reset mid-recovery: immediate return to IDLE with all outputs at reset values. No partial write or redirect may be emitted after rsn_i deasserts.

Test Plan:
1. Reset: rsn_i=0 asynchronously mid-cycle -> all outputs 0 before next clock edge; state IDLE.
2. Three-entry recovery, FLUSH_CYCLES=2, exc_pc_i=0x100, entries popped in order (x5,0xAAAA), (x6,0xBBBB), (x7,0xCCCC):
   - flush_o high for 2 cycles;
   - rf_we_o pulses writing x5/x6/x7 in pop order;
   - rollback_cnt_o=3, pc_redirect_o one cycle with pc_target_o=0x2000, epc_o=0x100.
3. Entry with dest x0 between x3 and x4 -> only 2 rf_we_o pulses; rollback_cnt_o=3.
4. Empty history file recovery -> no rf writes; redirect exactly FLUSH_CYCLES+2 cycles after entry; rollback_cnt_o=0.
5. hf_empty_i=1 for 2 cycles with hf_recovering_i=1, then one more entry -> block stays in ROLLBACK and restores the late entry before redirecting.
6. rsn_i asserted during ROLLBACK after 1 of 4 writes -> no further writes, no pc_redirect_o; a clean recovery after reset completes normally.
